led_trail_fader: RTL

//  Downstream stage of the LED sweep pattern generator on DE2-115.

---
 rtl/led_trail_fader.sv | 79 +++++++
 1 files changed

// File: rtl/led_trail_fader.sv
// Comet-tail fader for the LED sweep: each LED holds a brightness level that is
// reloaded while its pattern bit is lit and decays afterwards. A shared PWM counter renders the levels.
module led_trail_fader #(
    parameter int N_LEDS       = 18,
    parameter int LEVEL_W      = 4,
    parameter int PWM_DIV      = 16,
    parameter int DECAY_CYCLES = 1_250_000
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [N_LEDS-1:0] pattern_in,
    input  logic              fade_en,
    output logic [N_LEDS-1:0] LEDR
);

    localparam int DW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [DW-1:0]      DECAY_LAST = DW'(DECAY_CYCLES - 1);
    localparam logic [PW-1:0]      PRE_LAST   = PW'(PWM_DIV - 1);
    localparam logic [LEVEL_W-1:0] MAX_LEVEL  = '1;

    logic [DW-1:0]                    decay_cnt_q, decay_cnt_d;
    logic [PW-1:0]                    pwm_pre_q, pwm_pre_d;
    logic [LEVEL_W-1:0]               pwm_cnt_q, pwm_cnt_d;
    logic [N_LEDS-1:0][LEVEL_W-1:0]   level_q, level_d;
    logic [N_LEDS-1:0]                ledr_q, ledr_d;
    logic                             decay_tick;
    logic                             pwm_wrap;

    assign decay_tick = (decay_cnt_q == DECAY_LAST);
    assign pwm_wrap   = (pwm_pre_q == PRE_LAST);

    always_comb begin
        decay_cnt_d = decay_tick ? '0 : decay_cnt_q + DW'(1);
        pwm_pre_d   = pwm_wrap ? '0 : pwm_pre_q + PW'(1);
        pwm_cnt_d   = pwm_wrap ? pwm_cnt_q + LEVEL_W'(1) : pwm_cnt_q;
    end

    // A lit bit always reloads, even on a decay tick, so the head of the comet never dims.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < N_LEDS; i++) begin
            if (pattern_in[i]) begin
                level_d[i] = MAX_LEVEL;
            end else if (!fade_en) begin
                level_d[i] = '0;
            end else if (decay_tick && (level_q[i] != '0)) begin
                level_d[i] = level_q[i] - LEVEL_W'(1);
            end
        end
    end

    // Full level is forced solid because the counter can never exceed MAX_LEVEL.
    always_comb begin
        ledr_d = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            ledr_d[i] = (level_q[i] == MAX_LEVEL) | (pwm_cnt_q < level_q[i]);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            decay_cnt_q <= '0;
            pwm_pre_q   <= '0;
            pwm_cnt_q   <= '0;
            level_q     <= '0;
            ledr_q      <= '0;
        end else begin
            decay_cnt_q <= decay_cnt_d;
            pwm_pre_q   <= pwm_pre_d;
            pwm_cnt_q   <= pwm_cnt_d;
            level_q     <= level_d;
            ledr_q      <= ledr_d;
        end
    end

    assign LEDR = ledr_q;

endmodule
